// File: rtl/ucsbece154_imem_prefetch.sv
// Instruction-memory model of a burst SDRAM: critical-word-first demand
// block followed by sequential prefetch blocks read from a text image.
module ucsbece154_imem_prefetch #(
  parameter int unsigned TEXT_SIZE       = 64,
  parameter logic [31:0] TEXT_START      = 32'h00010000,
  parameter int unsigned BLOCK_WORDS     = 4,
  parameter int unsigned T0_DELAY        = 40,
  parameter int unsigned PREFETCH_BLOCKS = 1,
  parameter int unsigned PF_GAP          = 0,
  parameter logic [31:0] TEXT_IMAGE [TEXT_SIZE] = '{default: '0}
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           ReadRequest,
  input  logic [31:0]                    ReadAddress,
  output logic [31:0]                    DataIn,
  output logic                           DataReady,
  output logic [$clog2(BLOCK_WORDS)-1:0] WordIndex,
  output logic                           BlockIsPrefetch,
  output logic                           BlockDone,
  output logic                           Busy
);

  localparam int unsigned LBW = $clog2(BLOCK_WORDS);
  localparam int unsigned IW  = $clog2(TEXT_SIZE);
  localparam int unsigned WCW = ($clog2(T0_DELAY + 1) > 4) ? $clog2(T0_DELAY + 1) : 4;

  localparam logic [32:0] TEXT_END_RAW = {1'b0, TEXT_START} + 33'(4 * TEXT_SIZE);
  localparam logic [32:0] TEXT_END     = (TEXT_END_RAW < 33'h010000000) ? TEXT_END_RAW
                                                                        : 33'h010000000;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_T0  = 3'd1;
  localparam logic [2:0] S_SEND_DEM = 3'd2;
  localparam logic [2:0] S_PF_WAIT  = 3'd3;
  localparam logic [2:0] S_SEND_PF  = 3'd4;

  logic [2:0]        state_q;
  logic [29-LBW:0]   blk_q;       // block number (word address without in-block bits)
  logic [LBW-1:0]    crit_q;      // first word index of the current block
  logic [LBW-1:0]    word_cnt_q;  // words already delivered from the current block
  logic [2:0]        blk_cnt_q;   // prefetch blocks started so far
  logic [WCW-1:0]    wait_cnt_q;

  logic [LBW-1:0]    cur_idx;
  logic [29:0]       cur_word;
  logic [31:0]       cur_addr;
  logic [29-LBW:0]   next_blk;
  logic [31:0]       next_addr;
  logic              sending;
  logic              last_word;
  logic              more_pf;
  logic [IW-1:0]     mem_idx;
  logic              unused_addr_bits;

  function automatic logic in_text(input logic [31:0] a);
    return ({1'b0, a} >= {1'b0, TEXT_START}) && ({1'b0, a} < TEXT_END);
  endfunction

  // Byte address bits [1:0] carry no meaning for word fetches.
  assign unused_addr_bits = ^ReadAddress[1:0];

  // Current word address, block-end decisions and output decode.
  always_comb begin
    cur_idx   = crit_q + word_cnt_q;
    cur_word  = {blk_q, cur_idx};
    cur_addr  = {cur_word, 2'b00};
    next_blk  = blk_q + 1'b1;
    next_addr = {next_blk, {LBW{1'b0}}, 2'b00};
    sending   = (state_q == S_SEND_DEM) || (state_q == S_SEND_PF);
    last_word = (word_cnt_q == LBW'(BLOCK_WORDS - 1));
    more_pf   = (blk_cnt_q < 3'(PREFETCH_BLOCKS)) && in_text(next_addr);
    // Low bits of the offset only depend on low bits of both operands.
    mem_idx   = cur_word[IW-1:0] - TEXT_START[IW+1:2];

    DataReady       = sending;
    DataIn          = (sending && in_text(cur_addr)) ? TEXT_IMAGE[mem_idx] : '0;
    WordIndex       = sending ? cur_idx : '0;
    BlockIsPrefetch = (state_q == S_SEND_PF);
    BlockDone       = sending && last_word;
    Busy            = (state_q != S_IDLE);
  end

  // Burst sequencing: latency wait, block streaming, prefetch gaps.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      blk_q      <= '0;
      crit_q     <= '0;
      word_cnt_q <= '0;
      blk_cnt_q  <= '0;
      wait_cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ReadRequest) begin
            blk_q      <= ReadAddress[31:LBW+2];
            crit_q     <= ReadAddress[LBW+1:2];
            word_cnt_q <= '0;
            blk_cnt_q  <= '0;
            wait_cnt_q <= '0;
            state_q    <= S_WAIT_T0;
          end
        end
        S_WAIT_T0: begin
          if (wait_cnt_q == WCW'(T0_DELAY - 1)) begin
            wait_cnt_q <= '0;
            state_q    <= S_SEND_DEM;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        S_SEND_DEM, S_SEND_PF: begin
          if (last_word) begin
            word_cnt_q <= '0;
            if (more_pf) begin
              blk_q     <= next_blk;
              crit_q    <= '0;
              blk_cnt_q <= blk_cnt_q + 1'b1;
              state_q   <= (PF_GAP == 0) ? S_SEND_PF : S_PF_WAIT;
            end else begin
              state_q   <= S_IDLE;
            end
          end else begin
            word_cnt_q <= word_cnt_q + 1'b1;
          end
        end
        S_PF_WAIT: begin
          if (wait_cnt_q == WCW'(PF_GAP - 1)) begin
            wait_cnt_q <= '0;
            state_q    <= S_SEND_PF;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ucsbece154_imem_prefetch.sv
// Directed bench for ucsbece154_imem_prefetch: two instances (PF=1/GAP=0 and
// PF=2/GAP=2), cycle-by-cycle comparison against hand-built schedules.
module tb_ucsbece154_imem_prefetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] addr;
  logic        req1, req2;

  logic [31:0] d1_data, d2_data;
  logic        d1_rdy, d2_rdy;
  logic [1:0]  d1_idx, d2_idx;
  logic        d1_pf, d2_pf;
  logic        d1_done, d2_done;
  logic        d1_busy, d2_busy;

  // Image word i holds 0xC0DE0000 + byte offset, so data identifies its address.
  localparam logic [31:0] IMG [64] = '{
    32'hC0DE0000, 32'hC0DE0004, 32'hC0DE0008, 32'hC0DE000C, 32'hC0DE0010, 32'hC0DE0014, 32'hC0DE0018, 32'hC0DE001C,
    32'hC0DE0020, 32'hC0DE0024, 32'hC0DE0028, 32'hC0DE002C, 32'hC0DE0030, 32'hC0DE0034, 32'hC0DE0038, 32'hC0DE003C,
    32'hC0DE0040, 32'hC0DE0044, 32'hC0DE0048, 32'hC0DE004C, 32'hC0DE0050, 32'hC0DE0054, 32'hC0DE0058, 32'hC0DE005C,
    32'hC0DE0060, 32'hC0DE0064, 32'hC0DE0068, 32'hC0DE006C, 32'hC0DE0070, 32'hC0DE0074, 32'hC0DE0078, 32'hC0DE007C,
    32'hC0DE0080, 32'hC0DE0084, 32'hC0DE0088, 32'hC0DE008C, 32'hC0DE0090, 32'hC0DE0094, 32'hC0DE0098, 32'hC0DE009C,
    32'hC0DE00A0, 32'hC0DE00A4, 32'hC0DE00A8, 32'hC0DE00AC, 32'hC0DE00B0, 32'hC0DE00B4, 32'hC0DE00B8, 32'hC0DE00BC,
    32'hC0DE00C0, 32'hC0DE00C4, 32'hC0DE00C8, 32'hC0DE00CC, 32'hC0DE00D0, 32'hC0DE00D4, 32'hC0DE00D8, 32'hC0DE00DC,
    32'hC0DE00E0, 32'hC0DE00E4, 32'hC0DE00E8, 32'hC0DE00EC, 32'hC0DE00F0, 32'hC0DE00F4, 32'hC0DE00F8, 32'hC0DE00FC
  };

  ucsbece154_imem_prefetch #(
    .TEXT_SIZE(64), .TEXT_START(32'h00010000), .BLOCK_WORDS(4), .T0_DELAY(40),
    .PREFETCH_BLOCKS(1), .PF_GAP(0), .TEXT_IMAGE(IMG)
  ) u_pf1 (
    .clk(clk), .reset(reset), .ReadRequest(req1), .ReadAddress(addr),
    .DataIn(d1_data), .DataReady(d1_rdy), .WordIndex(d1_idx),
    .BlockIsPrefetch(d1_pf), .BlockDone(d1_done), .Busy(d1_busy)
  );

  ucsbece154_imem_prefetch #(
    .TEXT_SIZE(64), .TEXT_START(32'h00010000), .BLOCK_WORDS(4), .T0_DELAY(40),
    .PREFETCH_BLOCKS(2), .PF_GAP(2), .TEXT_IMAGE(IMG)
  ) u_pf2 (
    .clk(clk), .reset(reset), .ReadRequest(req2), .ReadAddress(addr),
    .DataIn(d2_data), .DataReady(d2_rdy), .WordIndex(d2_idx),
    .BlockIsPrefetch(d2_pf), .BlockDone(d2_done), .Busy(d2_busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [31:0] exp_data(input logic [31:0] a);
    if (a >= 32'h00010000 && a < 32'h00010100) return 32'hC0DE0000 + (a - 32'h00010000);
    return 32'h0;
  endfunction

  typedef struct {
    logic        rdy;
    logic        busy;
    logic [31:0] a;
    logic [1:0]  idx;
    logic        pf;
    logic        done;
  } exp_t;

  exp_t exp_q[$];

  task automatic push_wait(input int n);
    exp_t e;
    e = '{rdy: 1'b0, busy: 1'b1, a: 32'h0, idx: 2'd0, pf: 1'b0, done: 1'b0};
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  task automatic push_idle();
    exp_t e;
    e = '{rdy: 1'b0, busy: 1'b0, a: 32'h0, idx: 2'd0, pf: 1'b0, done: 1'b0};
    exp_q.push_back(e);
  endtask

  // Words of one block at byte base 'base', starting at index 'crit'.
  task automatic push_block(input logic [31:0] base, input int crit, input logic pf);
    exp_t e;
    for (int j = 0; j < 4; j++) begin
      e.rdy  = 1'b1;
      e.busy = 1'b1;
      e.idx  = 2'((crit + j) % 4);
      e.a    = base + 32'(e.idx) * 4;
      e.pf   = pf;
      e.done = (j == 3);
      exp_q.push_back(e);
    end
  endtask

  // Compare one cycle per negedge against the queued schedule (up to max_cyc cycles).
  task automatic run_check(input int sel, input string tag, input int max_cyc);
    exp_t e;
    logic [31:0] g_data;
    logic [1:0]  g_idx;
    logic        g_rdy, g_pf, g_done, g_busy;
    int cyc;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < max_cyc) begin
      e = exp_q.pop_front();
      @(negedge clk);
      cyc++;
      if (sel == 1) begin
        g_data = d1_data; g_rdy = d1_rdy; g_idx = d1_idx; g_pf = d1_pf; g_done = d1_done; g_busy = d1_busy;
      end else begin
        g_data = d2_data; g_rdy = d2_rdy; g_idx = d2_idx; g_pf = d2_pf; g_done = d2_done; g_busy = d2_busy;
      end
      check_eq($sformatf("%s c%0d rdy", tag, cyc),  32'(g_rdy),  32'(e.rdy));
      check_eq($sformatf("%s c%0d busy", tag, cyc), 32'(g_busy), 32'(e.busy));
      check_eq($sformatf("%s c%0d data", tag, cyc), g_data, e.rdy ? exp_data(e.a) : 32'h0);
      check_eq($sformatf("%s c%0d idx", tag, cyc),  32'(g_idx),  e.rdy ? 32'(e.idx) : 32'h0);
      check_eq($sformatf("%s c%0d pf", tag, cyc),   32'(g_pf),   32'(e.rdy & e.pf));
      check_eq($sformatf("%s c%0d done", tag, cyc), 32'(g_done), 32'(e.rdy & e.done));
    end
    exp_q.delete();
  endtask

  // Request in cycle 0: high across one rising edge, optionally left high.
  task automatic start(input int sel, input logic [31:0] a, input logic hold);
    @(negedge clk);
    addr = a;
    if (sel == 1) req1 = 1'b1; else req2 = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) begin
      req1 = 1'b0;
      req2 = 1'b0;
    end
  endtask

  task automatic sched_pf1(input logic [31:0] dem_base, input int crit, input logic [31:0] pf_base);
    push_wait(40);
    push_block(dem_base, crit, 1'b0);
    push_block(pf_base, 0, 1'b1);
    push_idle();
  endtask

  initial begin
    reset = 1'b0;
    addr  = 32'h0;
    req1  = 1'b0;
    req2  = 1'b0;
    #12;
    check_eq("rst rdy",  32'(d1_rdy),  32'h0);
    check_eq("rst busy", 32'(d1_busy), 32'h0);
    check_eq("rst data", d1_data,      32'h0);
    check_eq("rst idx",  32'(d1_idx),  32'h0);
    check_eq("rst pf",   32'(d1_pf),   32'h0);
    check_eq("rst done", 32'(d1_done), 32'h0);
    check_eq("rst busy2", 32'(d2_busy), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 1: critical word first plus one back-to-back prefetch block
    start(1, 32'h00010008, 1'b0);
    sched_pf1(32'h00010000, 2, 32'h00010010);
    run_check(1, "t1", 1000);

    // 2: misaligned address behaves like aligned, then block-aligned request
    start(1, 32'h0001000B, 1'b0);
    sched_pf1(32'h00010000, 2, 32'h00010010);
    run_check(1, "t2a", 1000);
    start(1, 32'h00010000, 1'b0);
    sched_pf1(32'h00010000, 0, 32'h00010010);
    run_check(1, "t2b", 1000);

    // 3: last block of text; prefetch past TEXT_END dropped
    start(1, 32'h000100F4, 1'b0);
    push_wait(40);
    push_block(32'h000100F0, 1, 1'b0);
    push_idle();
    run_check(1, "t3", 1000);

    // demand outside text: words delivered as zero, no prefetch
    start(1, 32'h00020004, 1'b0);
    push_wait(40);
    push_block(32'h00020000, 1, 1'b0);
    push_idle();
    run_check(1, "oor", 1000);

    // 4: two prefetch blocks with two-cycle gaps
    start(2, 32'h00010000, 1'b0);
    push_wait(40);
    push_block(32'h00010000, 0, 1'b0);
    push_wait(2);
    push_block(32'h00010010, 0, 1'b1);
    push_wait(2);
    push_block(32'h00010020, 0, 1'b1);
    push_idle();
    run_check(2, "t4", 1000);

    // 5: asynchronous reset in cycle 43 aborts the burst
    start(1, 32'h00010008, 1'b0);
    sched_pf1(32'h00010000, 2, 32'h00010010);
    run_check(1, "t5pre", 42);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_eq("t5 rdy async",  32'(d1_rdy),  32'h0);
    check_eq("t5 busy async", 32'(d1_busy), 32'h0);
    check_eq("t5 data async", d1_data,      32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("t5 rdy idle",  32'(d1_rdy),  32'h0);
    check_eq("t5 busy idle", 32'(d1_busy), 32'h0);
    start(1, 32'h00010008, 1'b0);
    sched_pf1(32'h00010000, 2, 32'h00010010);
    run_check(1, "t5post", 1000);

    // 6: request held high -> next burst accepted in the IDLE cycle
    start(1, 32'h00010008, 1'b1);
    sched_pf1(32'h00010000, 2, 32'h00010010);
    push_wait(40);
    run_check(1, "t6a", 1000);
    req1 = 1'b0;
    push_block(32'h00010000, 2, 1'b0);
    push_block(32'h00010010, 0, 1'b1);
    push_idle();
    push_idle();
    run_check(1, "t6b", 1000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, %0d/%0d passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
